// File: rtl/serial_load_sched.sv
// serial_load_sched: round-robin scheduler shifting the shared serial IN into
// one of three bit-slice registers at a time, MSB first, with a done strobe.
module serial_load_sched #(
  parameter int WIDTH = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IN,
  input  logic [3:1]     REQ,
  output logic [3:1]     GNT,
  output logic [3:1]     DONE,
  output logic           BUSY,
  output logic [WIDTH:1] REG1,
  output logic [WIDTH:1] REG2,
  output logic [WIDTH:1] REG3
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
  state_t state, state_n;
  logic [3:1] gnt_n, done_n, rq, pk, win, ld;
  logic [1:0] ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH:1] sel;
  logic last;
  // Rotate REQ so bit 1 is the requester just after ptr, pick the lowest, rotate back.
  always_comb begin
    rq  = ptr == 2'd1 ? {REQ[1], REQ[3], REQ[2]} : ptr == 2'd2 ? {REQ[2], REQ[1], REQ[3]} : REQ;
    pk  = rq[1] ? 3'b001 : rq[2] ? 3'b010 : rq[3] ? 3'b100 : 3'b000;
    win = ptr == 2'd1 ? {pk[2], pk[1], pk[3]} : ptr == 2'd2 ? {pk[1], pk[3], pk[2]} : pk;
  end
  always_comb begin
    sel = '0;
    for (int i = 1; i <= WIDTH; i++) sel[i] = cnt == CW'(i);
  end
  assign last = cnt == CW'(1);
  assign ld   = state == LOAD ? GNT : 3'b000;
  assign BUSY = state != IDLE;
  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    done_n  = 3'b000;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: if (|REQ) begin
        state_n = LOAD;
        gnt_n   = win;
        cnt_n   = CW'(WIDTH);
      end
      LOAD: begin
        cnt_n = cnt - CW'(1);
        if (last) begin
          state_n = FIN;
          gnt_n   = 3'b000;
          done_n  = GNT;
          ptr_n   = GNT[1] ? 2'd1 : GNT[2] ? 2'd2 : 2'd3;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      GNT   <= 3'b000;
      DONE  <= 3'b000;
      ptr   <= 2'd3;
      cnt   <= '0;
      REG1  <= '0;
      REG2  <= '0;
      REG3  <= '0;
    end else begin
      state <= state_n;
      GNT   <= gnt_n;
      DONE  <= done_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      REG1  <= ld[1] ? (REG1 & ~sel) | ({WIDTH{IN}} & sel) : REG1;
      REG2  <= ld[2] ? (REG2 & ~sel) | ({WIDTH{IN}} & sel) : REG2;
      REG3  <= ld[3] ? (REG3 & ~sel) | ({WIDTH{IN}} & sel) : REG3;
    end
  end
endmodule

// File: tb/tb_serial_load_sched.sv
// tb_serial_load_sched: directed checks of a WIDTH=2 scheduler plus a WIDTH=1 build.
module tb_serial_load_sched;
  logic CLK, RST, IN;
  logic [3:1] REQ, e_req;
  logic [3:1] GNT, DONE, e_gnt, e_done;
  logic BUSY, e_busy;
  logic [2:1] REG1, REG2, REG3;
  logic [1:1] e_r1, e_r2, e_r3;
  int passed = 0, total = 0;

  serial_load_sched #(.WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .REQ(REQ), .GNT(GNT), .DONE(DONE), .BUSY(BUSY),
    .REG1(REG1), .REG2(REG2), .REG3(REG3));
  serial_load_sched #(.WIDTH(1)) dut1 (
    .CLK(CLK), .RST(RST), .IN(IN), .REQ(e_req), .GNT(e_gnt), .DONE(e_done), .BUSY(e_busy),
    .REG1(e_r1), .REG2(e_r2), .REG3(e_r3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    RST = 1'b0; REQ = 3'b000; e_req = 3'b000; IN = 1'b0;
    // reset holds everything idle regardless of inputs
    for (int i = 0; i < 4; i++) begin
      REQ = 3'($urandom_range(0, 7)); IN = 1'($urandom_range(0, 1));
      tick();
      chk("reset_outs", {GNT, DONE, BUSY, REG1, REG2, REG3}, 0);
    end
    REQ = 3'b000; IN = 1'b0; RST = 1'b1;
    tick(); tick();
    chk("idle_after_reset", {GNT, BUSY}, 0);
    // single load into REG1
    REQ = 3'b001;
    tick(); chk("single_gnt", GNT, 3'b001); chk("single_busy", BUSY, 1);
    REQ = 3'b000; IN = 1'b1;
    tick(); chk("single_done_early", DONE, 0); IN = 1'b0;
    tick(); chk("single_done", DONE, 3'b001); chk("single_gnt_off", GNT, 0);
    chk("single_reg1", REG1, 2'b10); chk("single_reg23", {REG2, REG3}, 0);
    tick(); chk("single_done_off", DONE, 0); chk("single_fin_busy", BUSY, 0);
    // contention after reset: order 1,2,3,1 with 4-cycle spacing
    #1 RST = 1'b0; #1;
    chk("async_reset_reg1", REG1, 0);
    RST = 1'b1; REQ = 3'b111; IN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("cont_gnt", GNT, 3'b001 << (k % 3));
      tick(); chk("cont_busy", BUSY, 1);
      tick(); chk("cont_done", DONE, 3'b001 << (k % 3)); chk("cont_gnt_off", GNT, 0);
      if (k == 3) REQ = 3'b000;
      tick(); chk("cont_done_off", DONE, 0);
    end
    chk("cont_regs", {REG1, REG2, REG3}, 6'b111111);
    // fairness: after requester 2, contention 1+2 grants 1 first then 2
    REQ = 3'b010; IN = 1'b0;
    tick(); chk("fair_g2", GNT, 3'b010); REQ = 3'b011;
    tick(); tick(); tick();
    tick(); chk("fair_g1_first", GNT, 3'b001);
    tick(); tick(); tick();
    tick(); chk("fair_g2_next", GNT, 3'b010); REQ = 3'b000;
    tick(); tick(); chk("fair_reg1", REG1, 2'b00); tick();
    REQ = 3'b100;
    tick(); chk("fair_g3", GNT, 3'b100); REQ = 3'b111;
    tick(); tick(); tick();
    tick(); chk("fair_after3_g1", GNT, 3'b001); REQ = 3'b000;
    tick(); tick(); tick();
    // request drop mid-load still completes
    REQ = 3'b100; IN = 1'b0;
    tick(); chk("drop_gnt", GNT, 3'b100);
    tick(); REQ = 3'b000; IN = 1'b1;
    tick(); chk("drop_done", DONE, 3'b100); chk("drop_reg3", REG3, 2'b01);
    tick(); tick(); chk("drop_idle", {GNT, DONE, BUSY}, 0);
    // reset mid-load clears everything and restores priority to requester 1
    REQ = 3'b110; IN = 1'b1;
    tick(); chk("rml_gnt", GNT, 3'b010);
    tick(); chk("rml_partial", REG2, 2'b10);
    #1 RST = 1'b0; #1;
    chk("rml_cleared", {GNT, DONE, BUSY, REG1, REG2, REG3}, 0);
    tick(); chk("rml_no_done", DONE, 0);
    RST = 1'b1; REQ = 3'b111;
    tick(); chk("rml_next_g1", GNT, 3'b001); REQ = 3'b000;
    tick(); tick(); tick();
    // WIDTH=1 build
    e_req = 3'b010; IN = 1'b1;
    tick(); chk("w1_gnt", e_gnt, 3'b010); e_req = 3'b000;
    tick(); chk("w1_done", e_done, 3'b010); chk("w1_reg2", e_r2, 1'b1);
    chk("w1_others", {e_r1, e_r3}, 0);
    tick(); chk("w1_done_off", {e_done, e_busy}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_load_sched.md
# serial_load_sched

Round-robin scheduler that shares the single serial input `IN` among three `[WIDTH:1]` bit-slice registers. Each register owner raises a request. The scheduler grants one requester at a time and shifts `WIDTH` consecutive `IN` samples into that requester's register, MSB first. It then pulses a per-requester done strobe. It sits between the shared `IN` source and the `REG1`/`REG2`/`REG3` storage, so no slice is ever written by two loaders at once.

## Interface
Parameters:
- `WIDTH`, default 2: bits per register, indexed `[WIDTH:1]`. Legal range is 1..16.

Ports:
- `CLK`, input, 1: clock, rising edge.
- `RST`, input, 1: reset, asynchronous, active-low.
- `IN`, input, 1: shared serial data, sampled only in LOAD.
- `REQ`, input, `[3:1]`: load requests, level-sensitive, one bit per register.
- `GNT`, output, `[3:1]`: one-hot grant; all zeros when not loading.
- `DONE`, output, `[3:1]`: one-cycle completion strobe for the granted requester.
- `BUSY`, output, 1: high whenever state is not IDLE.
- `REG1`, output, `[WIDTH:1]`: register 1.
- `REG2`, output, `[WIDTH:1]`: register 2.
- `REG3`, output, `[WIDTH:1]`: register 3.

## Operation
- **Reset values.** While `RST`=0, state is IDLE. `GNT`=0, `DONE`=0, `BUSY`=0, `REG1`..`REG3`=0. The round-robin pointer is 3, so requester 1 has first priority. The bit counter is 0.
- **States.** IDLE, LOAD, FIN.
- **IDLE.**
  - If `REQ` is nonzero, the winner is the first set bit scanning from pointer+1, wrapping 3→1.
  - At the next edge: `GNT`=onehot(winner), counter=`WIDTH`, state goes to LOAD.
  - If `REQ`=0, the block stays in IDLE.
- **LOAD.**
  - Each edge writes `IN` into `REGk[counter]` for the granted k, then decrements the counter.
  - When the edge writes bit 1, the next state is FIN. At that same edge `GNT` goes to 0, `DONE[k]` goes to 1, and the pointer becomes k.
  - Only the granted register changes. The other registers, and the unwritten bits of the granted register, hold their values.
- **FIN.** Lasts exactly one cycle. `DONE` returns to 0 at the next edge and the state returns to IDLE. `REQ` is not sampled during FIN.
- **Request drop.** Deasserting `REQ[k]` during LOAD does not abort; the load completes and `DONE[k]` still pulses.
- **Re-grant.** A requester still holding `REQ` after its `DONE` competes normally at the next IDLE. Round-robin order means it loses to any other active requester.
- **Counter width.** The counter is `clog2(WIDTH+1)` bits. It never underflows, because the transition to FIN happens when the counter equals 1.
- **Reset during a load.** Asserting `RST` at any time forces all reset values immediately. A partially written register is cleared, and no `DONE` is issued.

## Timing
- **Request latency.** `REQ` sampled high at edge E in IDLE gives `GNT` high after E.
- **Data sampling.** `IN` is sampled at edges E+1 … E+`WIDTH`, writing bits `WIDTH`…1 in that order.
- **Done strobe.** `DONE[k]` is high for the cycle after edge E+`WIDTH`.
- **Grant spacing.** The earliest next grant edge is E+`WIDTH`+2, so the grant-to-grant period is `WIDTH`+2 cycles.
- **Visibility.** Register bits are visible the cycle after their write edge. The final bit is therefore visible in the same cycle as `DONE`.
- **Invariants.** `GNT` and `DONE` are each one-hot or zero, and never high in the same cycle. `BUSY` is high from E to E+`WIDTH`+1 inclusive.

## Test plan
1. **Reset check.** Hold `RST`=0 with random `REQ`/`IN` → all outputs stay 0 and no `GNT` appears. Release `RST` → still idle until a request arrives.
2. **Single load.** `WIDTH`=2, `REQ`=3'b001 at edge E, `IN`=1 at E+1 and 0 at E+2 → `REG1`=2'b10. `DONE`=3'b001 for one cycle after E+2. `REG2` and `REG3` stay 0.
3. **Contention after reset.** `REQ`=3'b111 held → grant order 1, 2, 3, 1, with grant edges spaced 4 cycles apart. Each `DONE` pulse matches the preceding grant.
4. **Round-robin fairness.** Load requester 2 only, then `REQ`=3'b011 → requester 1 is granted first, then 2. Load requester 3 only, then `REQ`=3'b111 → requester 1 first.
5. **Request drop.** Drop `REQ[3]` one cycle into LOAD with `IN` stream 0,1 → `REG3`=2'b01 and `DONE[3]` still pulses.
6. **Reset mid-load, plus `WIDTH`=1 build.**
   - Assert `RST` after the first LOAD edge → `REG1`..`REG3`=0, no `DONE`, and the next grant goes to requester 1.
   - With `WIDTH`=1, `REQ`=3'b010 and `IN`=1 → `REG2`=1'b1 with `DONE[2]` high 2 cycles after the request edge.
